// File: rtl/ita_regfile_ctrl_pkg.sv
// Shared types for the register file controller: the sweep/arbitration FSM states.
package ita_regfile_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DRAIN
  } state_e;

endpackage

// File: rtl/ita_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module ita_rr_arbiter #(
  parameter int N    = 2,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    logic found;
    int   cand;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/ita_regfile_ctrl.sv
// Write arbiter, hazard-aware read issue and zero-fill sweep for the latch-based
// 1W/multi-read register file (the array itself is instantiated by the parent).
module ita_regfile_ctrl
  import ita_regfile_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITERS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_i,
  output logic                             busy_o,
  input  logic [N_WRITERS-1:0]             wr_req_i,
  input  logic [N_WRITERS*ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [N_WRITERS*DATA_WIDTH-1:0]  wr_data_i,
  output logic [N_WRITERS-1:0]             wr_gnt_o,
  input  logic [N_READ-1:0]                rd_req_i,
  input  logic [N_READ*ADDR_WIDTH-1:0]     rd_addr_i,
  output logic [N_READ-1:0]                rd_gnt_o,
  output logic [N_READ-1:0]                rd_valid_o,
  output logic [N_READ*DATA_WIDTH-1:0]     rd_data_o,
  output logic [N_READ-1:0]                rf_read_enable_o,
  output logic [N_READ*ADDR_WIDTH-1:0]     rf_read_addr_o,
  input  logic [N_READ*DATA_WIDTH-1:0]     rf_read_data_i,
  output logic                             rf_write_enable_o,
  output logic [ADDR_WIDTH-1:0]            rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]            rf_write_data_o
);

  localparam int IDXW = (N_WRITERS > 1) ? $clog2(N_WRITERS) : 1;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         rr_q, rr_d, win_idx;
  logic [ADDR_WIDTH-1:0]   clr_q, clr_d;
  logic                    busy_q;
  logic [N_READ-1:0]       rd_valid_q;
  logic [N_WRITERS-1:0]    arb_req, arb_gnt;
  logic                    idle;
  logic [ADDR_WIDTH-1:0]   wr_addr_arr [N_WRITERS];
  logic [DATA_WIDTH-1:0]   wr_data_arr [N_WRITERS];

  for (genvar gi = 0; gi < N_WRITERS; gi++) begin : g_wr_unpack
    assign wr_addr_arr[gi] = wr_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_arr[gi] = wr_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign idle    = (state_q == IDLE);
  assign arb_req = idle ? wr_req_i : '0;

  ita_rr_arbiter #(.N(N_WRITERS), .IDXW(IDXW)) u_arb (
    .req (arb_req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (win_idx)
  );

  assign wr_gnt_o = arb_gnt;

  always_comb begin
    state_d           = state_q;
    clr_d             = clr_q;
    rr_d              = rr_q;
    rf_write_enable_o = 1'b0;
    rf_write_addr_o   = '0;
    rf_write_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (clear_i) state_d = CLEAR;
        if (|arb_gnt) begin
          rf_write_enable_o = 1'b1;
          rf_write_addr_o   = wr_addr_arr[win_idx];
          rf_write_data_o   = wr_data_arr[win_idx];
          rr_d = (win_idx == IDXW'(N_WRITERS - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      CLEAR: begin
        rf_write_enable_o = 1'b1;
        rf_write_addr_o   = clr_q;
        // Counter wraps to 0 on the last address, ready for the next sweep.
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A read racing a same-cycle write to its word is held off one cycle.
  for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
    logic hazard;
    assign hazard = rf_write_enable_o &
                    (rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH] == rf_write_addr_o);
    assign rd_gnt_o[gi]         = rd_req_i[gi] & idle & ~hazard;
    assign rf_read_enable_o[gi] = rd_gnt_o[gi];
    assign rf_read_addr_o[gi*ADDR_WIDTH +: ADDR_WIDTH] =
           rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign rd_data_o  = rf_read_data_i;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      clr_q      <= '0;
      busy_q     <= 1'b0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      clr_q      <= clr_d;
      busy_q     <= (state_d != IDLE);
      rd_valid_q <= rd_gnt_o;
    end
  end

endmodule

// File: tb/tb_ita_regfile_ctrl.sv
// Directed bench for ita_regfile_ctrl with a behavioural register file model and
// a read-response scoreboard checked by an independent monitor.
module tb_ita_regfile_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear_i = 1'b0;
  logic             busy_o;
  logic [NW-1:0]    wr_req_i = '0;
  logic [NW*AW-1:0] wr_addr_i = '0;
  logic [NW*DW-1:0] wr_data_i = '0;
  logic [NW-1:0]    wr_gnt_o;
  logic [NR-1:0]    rd_req_i = '0;
  logic [NR*AW-1:0] rd_addr_i = '0;
  logic [NR-1:0]    rd_gnt_o;
  logic [NR-1:0]    rd_valid_o;
  logic [NR*DW-1:0] rd_data_o;
  logic [NR-1:0]    rf_read_enable_o;
  logic [NR*AW-1:0] rf_read_addr_o;
  logic [NR*DW-1:0] rf_read_data_i;
  logic             rf_write_enable_o;
  logic [AW-1:0]    rf_write_addr_o;
  logic [DW-1:0]    rf_write_data_o;

  always #5 clk = ~clk;

  ita_regfile_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITERS(NW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .clear_i           (clear_i),
    .busy_o            (busy_o),
    .wr_req_i          (wr_req_i),
    .wr_addr_i         (wr_addr_i),
    .wr_data_i         (wr_data_i),
    .wr_gnt_o          (wr_gnt_o),
    .rd_req_i          (rd_req_i),
    .rd_addr_i         (rd_addr_i),
    .rd_gnt_o          (rd_gnt_o),
    .rd_valid_o        (rd_valid_o),
    .rd_data_o         (rd_data_o),
    .rf_read_enable_o  (rf_read_enable_o),
    .rf_read_addr_o    (rf_read_addr_o),
    .rf_read_data_i    (rf_read_data_i),
    .rf_write_enable_o (rf_write_enable_o),
    .rf_write_addr_o   (rf_write_addr_o),
    .rf_write_data_o   (rf_write_data_o)
  );

  // Register file model: write sampled at the edge, read address registered,
  // unwritten words return a recognisable non-zero pattern.
  logic [DW-1:0] rf_mem [32];
  logic [31:0]   rf_vld = '0;
  logic [AW-1:0] rf_raddr [NR] = '{default: '0};

  always @(posedge clk) begin
    if (rf_write_enable_o) begin
      rf_mem[rf_write_addr_o] <= rf_write_data_o;
      rf_vld[rf_write_addr_o] <= 1'b1;
    end
    for (int p = 0; p < NR; p++)
      if (rf_read_enable_o[p]) rf_raddr[p] <= rf_read_addr_o[p*AW +: AW];
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rf_rd
    assign rf_read_data_i[gi*DW +: DW] = rf_vld[rf_raddr[gi]] ? rf_mem[rf_raddr[gi]]
                                         : {16'hA5A5, 11'd0, rf_raddr[gi]};
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end else begin
      $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_addr_i[w*AW +: AW] = a;
    wr_data_i[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr_i[p*AW +: AW] = a;
  endtask

  task automatic push_rd(input int p, input logic [DW-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc_cnt + 1;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every valid read pops the scoreboard; an expected response whose
  // cycle passes without rd_valid_o is reported as missing.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rd_valid_o[0]) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd0_unexpected: got valid data 0x%08h expected no response", rd_data_o[31:0]);
        end else begin
          e = q0.pop_front();
          chk("rd0_data", rd_data_o[31:0], e.data);
          chk("rd0_cycle", 32'(cyc_cnt), 32'(e.cyc));
        end
      end else if (q0.size() > 0 && q0[0].cyc <= cyc_cnt) begin
        e = q0.pop_front();
        chk("rd0_valid_missing", 32'(rd_valid_o[0]), 32'd1);
      end
      if (rd_valid_o[1]) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rd1_unexpected: got valid data 0x%08h expected no response", rd_data_o[63:32]);
        end else begin
          e = q1.pop_front();
          chk("rd1_data", rd_data_o[63:32], e.data);
          chk("rd1_cycle", 32'(cyc_cnt), 32'(e.cyc));
        end
      end else if (q1.size() > 0 && q1[0].cyc <= cyc_cnt) begin
        e = q1.pop_front();
        chk("rd1_valid_missing", 32'(rd_valid_o[1]), 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_req_v [9] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11};
  logic [1:0] rr_gnt_v [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rf_we", 32'(rf_write_enable_o), 32'd0);
    chk("rst_rf_re", 32'(rf_read_enable_o), 32'd0);
    tick();
    rst_n = 1'b1;

    // Zero-fill sweep with every requester active; nothing may be granted.
    clear_i = 1'b1;
    @(negedge clk);
    chk("sweep_busy_pre", 32'(busy_o), 32'd0);
    tick();
    clear_i  = 1'b0;
    wr_req_i = 2'b11;
    rd_req_i = 2'b11;
    set_wr(0, 5'd9, 32'h1234_5678);
    set_wr(1, 5'd9, 32'h8765_4321);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("sweep_busy", 32'(busy_o), 32'd1);
      chk("sweep_we", 32'(rf_write_enable_o), 32'd1);
      chk("sweep_addr", 32'(rf_write_addr_o), 32'(k));
      chk("sweep_data", rf_write_data_o, 32'd0);
      chk("sweep_wr_gnt", 32'(wr_gnt_o), 32'd0);
      chk("sweep_rd_gnt", 32'(rd_gnt_o), 32'd0);
      tick();
    end
    @(negedge clk);
    chk("drain_busy", 32'(busy_o), 32'd1);
    chk("drain_we", 32'(rf_write_enable_o), 32'd0);
    chk("drain_wr_gnt", 32'(wr_gnt_o), 32'd0);
    chk("drain_rd_gnt", 32'(rd_gnt_o), 32'd0);
    tick();
    wr_req_i = '0;
    rd_req_i = '0;
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 32'd0);
    tick();

    // Every word reads back zero, back-to-back on both ports.
    rd_req_i = 2'b11;
    for (int a = 0; a < 32; a++) begin
      set_rd(0, 5'(a));
      set_rd(1, 5'(31 - a));
      @(negedge clk);
      chk("zero_rd_gnt", 32'(rd_gnt_o), 32'd3);
      push_rd(0, 32'd0);
      push_rd(1, 32'd0);
      tick();
    end
    rd_req_i = '0;
    tick();

    // Round robin: pointer advances only on grants.
    set_wr(0, 5'd10, 32'h0A0A_0A0A);
    set_wr(1, 5'd11, 32'h0B0B_0B0B);
    for (int i = 0; i < 9; i++) begin
      wr_req_i = rr_req_v[i];
      @(negedge clk);
      chk("rr_gnt", 32'(wr_gnt_o), 32'(rr_gnt_v[i]));
      if (rr_gnt_v[i] != 2'b00)
        chk("rr_waddr", 32'(rf_write_addr_o), (rr_gnt_v[i] == 2'b01) ? 32'd10 : 32'd11);
      tick();
    end
    wr_req_i = '0;

    // Same-address read is stalled one cycle and returns the new word.
    set_wr(0, 5'd7, 32'hDEAD_BEEF);
    wr_req_i = 2'b01;
    set_rd(0, 5'd7);
    rd_req_i = 2'b01;
    @(negedge clk);
    chk("haz_wr_gnt", 32'(wr_gnt_o), 32'd1);
    chk("haz_rd_gnt_T", 32'(rd_gnt_o), 32'd0);
    tick();
    wr_req_i = '0;
    @(negedge clk);
    chk("haz_rd_gnt_T1", 32'(rd_gnt_o), 32'd1);
    push_rd(0, 32'hDEAD_BEEF);
    tick();
    rd_req_i = '0;

    // Different-address read alongside a write: no stall, old value.
    set_wr(1, 5'd3, 32'h3333_3333);
    wr_req_i = 2'b10;
    @(negedge clk);
    chk("w3_gnt", 32'(wr_gnt_o), 32'd2);
    tick();
    set_wr(0, 5'd4, 32'h4444_4444);
    wr_req_i = 2'b01;
    set_rd(0, 5'd3);
    rd_req_i = 2'b01;
    @(negedge clk);
    chk("w4_gnt", 32'(wr_gnt_o), 32'd1);
    chk("nohaz_rd_gnt", 32'(rd_gnt_o), 32'd1);
    push_rd(0, 32'h3333_3333);
    tick();
    wr_req_i = '0;
    set_rd(1, 5'd4);
    rd_req_i = 2'b10;
    @(negedge clk);
    chk("rd4_gnt", 32'(rd_gnt_o), 32'd2);
    push_rd(1, 32'h4444_4444);
    tick();

    // Both ports on the same word.
    set_rd(0, 5'd10);
    set_rd(1, 5'd10);
    rd_req_i = 2'b11;
    @(negedge clk);
    chk("dual10_gnt", 32'(rd_gnt_o), 32'd3);
    push_rd(0, 32'h0A0A_0A0A);
    push_rd(1, 32'h0A0A_0A0A);
    tick();
    set_rd(0, 5'd11);
    set_rd(1, 5'd11);
    @(negedge clk);
    chk("dual11_gnt", 32'(rd_gnt_o), 32'd3);
    push_rd(0, 32'h0B0B_0B0B);
    push_rd(1, 32'h0B0B_0B0B);
    tick();
    rd_req_i = '0;
    tick();
    tick();
    @(negedge clk);
    chk("hold_valid", 32'(rd_valid_o), 32'd0);
    chk("hold_data0", rd_data_o[31:0], 32'h0B0B_0B0B);
    tick();

    // Reset in the middle of a sweep, then a fresh sweep from address 0.
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_we", 32'(rf_write_enable_o), 32'd0);
    tick();
    rst_n   = 1'b1;
    clear_i = 1'b1;
    @(negedge clk);
    chk("resweep_busy_pre", 32'(busy_o), 32'd0);
    tick();
    clear_i = 1'b0;
    @(negedge clk);
    chk("resweep_addr0", 32'(rf_write_addr_o), 32'd0);
    chk("resweep_busy", 32'(busy_o), 32'd1);
    tick();
    @(negedge clk);
    chk("resweep_addr1", 32'(rf_write_addr_o), 32'd1);
    n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    chk("resweep_len", 32'(n), 32'd32);
    set_rd(0, 5'd10);
    rd_req_i = 2'b01;
    @(negedge clk);
    chk("resweep_rd_gnt", 32'(rd_gnt_o), 32'd1);
    push_rd(0, 32'd0);
    tick();
    rd_req_i = '0;
    repeat (3) tick();

    chk("sb0_empty", 32'(q0.size()), 32'd0);
    chk("sb1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ita_regfile_ctrl.md
# ita_regfile_ctrl

Controller and arbiter for the latch-based multi-read-port register file (`ita_register_file_1w_multi_port_read`). It shares the single write port between `N_WRITERS` requesters with round-robin arbitration. It issues per-port reads with a valid/grant handshake and stalls reads that would race a same-cycle write to the same word. On request it runs a zero-fill sweep, because the latch array has no reset.

## Interface
Parameters:
- `ADDR_WIDTH`, 5: register file address width; `NUM_WORDS = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 32: word width.
- `N_READ`, 2: read ports, one-to-one with register file read ports.
- `N_WRITERS`, 2: write requesters sharing the single write port, ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear_i` in 1: start the zero-fill sweep; sampled only in IDLE.
- `busy_o` out 1: sweep in progress (CLEAR or DRAIN).
- `wr_req_i` in `N_WRITERS`: write request per requester.
- `wr_addr_i` in `N_WRITERS×ADDR_WIDTH`: write address per requester.
- `wr_data_i` in `N_WRITERS×DATA_WIDTH`: write data per requester.
- `wr_gnt_o` out `N_WRITERS`: one-hot write grant; write accepted this cycle.
- `rd_req_i` in `N_READ`: read request per port.
- `rd_addr_i` in `N_READ×ADDR_WIDTH`: read address per port.
- `rd_gnt_o` out `N_READ`: read accepted this cycle.
- `rd_valid_o` out `N_READ`: read data valid, one cycle after grant.
- `rd_data_o` out `N_READ×DATA_WIDTH`: read data.
- `rf_read_enable_o` out `N_READ`: to register file `ReadEnable`.
- `rf_read_addr_o` out `N_READ×ADDR_WIDTH`: to register file `ReadAddr`.
- `rf_read_data_i` in `N_READ×DATA_WIDTH`: from register file `ReadData`.
- `rf_write_enable_o` out 1: to register file `WriteEnable`.
- `rf_write_addr_o` out `ADDR_WIDTH`: to register file `WriteAddr`.
- `rf_write_data_o` out `DATA_WIDTH`: to register file `WriteData`.

## Operation
- FSM states and transitions:
  - IDLE → CLEAR when `clear_i`=1.
  - CLEAR → DRAIN after the write to address `NUM_WORDS-1`.
  - DRAIN → IDLE unconditionally.
  - `clear_i` is ignored outside IDLE.
- Write arbitration (IDLE only):
  - Round-robin over `wr_req_i`, starting at the priority pointer `rr_q`; at most one grant per cycle.
  - `wr_gnt_o` and `rf_write_*` are combinational from the winner.
  - After a grant to index i, `rr_q` = (i+1) mod `N_WRITERS`. `rr_q` holds when there is no grant.
- CLEAR:
  - `rf_write_enable_o`=1, `rf_write_addr_o` = counter `clr_q`, `rf_write_data_o` = 0.
  - `clr_q` increments by 1 per cycle.
  - All `wr_gnt_o` and `rd_gnt_o` are 0.
- DRAIN: no grants; covers the commit of the last sweep write.
- Read ports, per port p:
  - `rd_gnt_o[p]` = `rd_req_i[p]` & state==IDLE & !hazard[p].
  - hazard[p] = `rf_write_enable_o` & (`rd_addr_i[p]` == `rf_write_addr_o`).
  - `rf_read_enable_o[p]` = `rd_gnt_o[p]`; `rf_read_addr_o[p]` = `rd_addr_i[p]`.
  - `rd_valid_o[p]` is registered from `rd_gnt_o[p]`.
  - `rd_data_o[p]` = `rf_read_data_i[p]` passthrough. It holds the last read word while `rd_valid_o`=0, because the register file keeps its read address.
- Read ports are independent of each other; any number may be granted in the same cycle.
- Reset values:
  - state IDLE, `rr_q`=0, `clr_q`=0, `rd_valid_o`=0, `busy_o`=0.
  - All grants and `rf_*` enables are 0.
- Reset during CLEAR aborts the sweep; array contents are undefined.

## Timing
- Write granted in cycle T: the register file samples data at edge T+1 and the latch commits during the high phase of T+1.
- A read granted in T+1 or later returns the new data, with `rd_valid_o` in T+2.
- A same-address read in cycle T is stalled and regranted in T+1, provided no new same-address write is granted.
- Read latency: grant in T → `rd_valid_o`=1 and data valid in T+1. Back-to-back grants give one result per cycle.
- Sweep: `clear_i` in T gives:
  - CLEAR during T+1 … T+`NUM_WORDS`;
  - DRAIN in T+`NUM_WORDS`+1;
  - IDLE, grants allowed, in T+`NUM_WORDS`+2.
  - `busy_o` is high in exactly the CLEAR and DRAIN cycles.
- `clr_q` wraps to 0 after the last address, ready for the next sweep.
- `busy_o` and `rd_valid_o` are registered; grants are combinational from requests and state.

## Structure
- Package `ita_regfile_ctrl_pkg`: FSM state enum `{IDLE, CLEAR, DRAIN}`.
- Sub-module `ita_rr_arbiter`, parameterised by N, one instance:
  - inputs: req vector, pointer;
  - outputs: one-hot grant and winner index;
  - purely combinational; the pointer register lives in the controller.
- The controller does not instantiate the register file; the top level connects `rf_*` to it.

## Test plan
- Reset, then `clear_i` pulse with `ADDR_WIDTH`=5:
  - `busy_o` high for 33 cycles;
  - writes of 0 to addresses 0..31, one per cycle;
  - all reads of any address then return 0.
- Both writers request continuously: grants alternate 0,1,0,1; `rr_q` advances only on grants.
- Write 0xDEADBEEF to address 7 in cycle T while port 0 reads address 7:
  - `rd_gnt_o[0]`=0 in T and 1 in T+1;
  - `rd_data_o[0]`=0xDEADBEEF with `rd_valid_o` in T+2.
- Port 0 reads address 3 while a write goes to address 4 in the same cycle: no stall; old value of address 3 valid next cycle.
- Both ports read the same address in one cycle: both granted, identical data next cycle.
- Assert `rst_n` low mid-CLEAR:
  - immediate IDLE, `busy_o`=0;
  - a subsequent `clear_i` sweeps from address 0 again.
